// File: rtl/sync_bus_arb.sv
// sync_bus_arb
//   Round-robin arbiter and pacing controller in the clka domain. It shares a
//   single en/d pulse-qualified clka->clkb bus crossing among NUM_REQ
//   requesters. The arbiter picks one requester and registers its word onto
//   bus_d. It fires a one-cycle bus_en launch pulse, then holds bus_d and
//   src_id frozen for HOLD_CYCLES cycles while the pulse crosses into clkb.
//
// Ports
//   clka      in   clock, all logic on the rising edge
//   clka_rst  in   asynchronous active-high reset
//   req       in   per-requester request level, held until ack
//   req_data  in   word i at [i*BUS_WIDTH +: BUS_WIDTH], stable while req[i]=1
//   ack       out  one-cycle pulse, requester i's word has been captured
//   bus_d     out  registered data to the crossing d input
//   bus_en    out  one-cycle launch pulse to the crossing en input
//   src_id    out  index of the requester that owns bus_d
//   busy      out  high while the transfer is being held
module sync_bus_arb #(
  parameter int unsigned           NUM_REQ     = 4,
  parameter int unsigned           BUS_WIDTH   = 8,
  parameter int unsigned           HOLD_CYCLES = 6,
  parameter logic [BUS_WIDTH-1:0]  RESET_VAL   = '0,
  localparam int unsigned          ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         clka,
  input  logic                         clka_rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [BUS_WIDTH-1:0]         bus_d,
  output logic                         bus_en,
  output logic [ID_W-1:0]              src_id,
  output logic                         busy
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

  state_e                 state_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic [BUS_WIDTH-1:0]   bus_d_q;
  logic                   bus_en_q;
  logic [ID_W-1:0]        src_id_q;
  logic                   busy_q;

  logic                   win_vld_d;
  logic [ID_W-1:0]        win_id_d;
  logic [BUS_WIDTH-1:0]   win_data_d;

  logic [BUS_WIDTH-1:0]   words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign words[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
  end

  // Walk the ring starting at the slot after the previous winner. The first
  // requester found wins, so a requester that keeps req high goes behind
  // every other pending requester.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_vld_d  = 1'b0;
    win_id_d   = '0;
    win_data_d = '0;
    idx        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_vld_d && req[idx]) begin
        win_vld_d  = 1'b1;
        win_id_d   = idx;
        win_data_d = words[idx];
      end
    end
  end

  always_ff @(posedge clka or posedge clka_rst) begin
    if (clka_rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      ack_q    <= '0;
      bus_d_q  <= RESET_VAL;
      bus_en_q <= 1'b0;
      src_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      bus_en_q <= 1'b0;
      ack_q    <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            state_q  <= S_HOLD;
            cnt_q    <= CNT_W'(HOLD_CYCLES - 1);
            bus_d_q  <= win_data_d;
            src_id_q <= win_id_d;
            rr_ptr_q <= win_id_d;
            bus_en_q <= 1'b1;
            ack_q    <= NUM_REQ'(1) << win_id_d;
            busy_q   <= 1'b1;
          end
        end
        S_HOLD: begin
          // req is ignored here; bus_d and src_id stay frozen.
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign ack    = ack_q;
  assign bus_d  = bus_d_q;
  assign bus_en = bus_en_q;
  assign src_id = src_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_sync_bus_arb.sv
module tb_sync_bus_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned H   = 6;
  localparam int unsigned IDW = $clog2(N);
  localparam logic [W-1:0] RV = 8'h00;

  logic           clka = 1'b0;
  logic           clka_rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   bus_d;
  logic           bus_en;
  logic [IDW-1:0] src_id;
  logic           busy;

  sync_bus_arb #(
    .NUM_REQ    (N),
    .BUS_WIDTH  (W),
    .HOLD_CYCLES(H),
    .RESET_VAL  (RV)
  ) dut (
    .clka    (clka),
    .clka_rst(clka_rst),
    .req     (req),
    .req_data(req_data),
    .ack     (ack),
    .bus_d   (bus_d),
    .bus_en  (bus_en),
    .src_id  (src_id),
    .busy    (busy)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [W-1:0] data;
    int unsigned id;
    logic [N-1:0] ackv;
  } launch_t;

  launch_t exp_q[$];
  launch_t log_q[$];

  // Reference model state: launches are allowed at or after next_ok
  int unsigned  cyc = 0;
  int unsigned  next_ok = 0;
  int unsigned  last_id = N - 1;
  int unsigned  hold_end = 0;
  logic [W-1:0] cur_word = RV;
  int unsigned  cur_id = 0;

  bit auto_en = 0;
  int drop_in [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a launch at edge e blocks further launches until e+H+1.
  initial begin
    forever begin
      @(posedge clka);
      cyc++;
      if (clka_rst) begin
        exp_q.delete();
        next_ok  = 0;
        last_id  = N - 1;
        hold_end = 0;
        cur_word = RV;
        cur_id   = 0;
      end else if (cyc >= next_ok && req != '0) begin
        int unsigned k;
        bit found;
        launch_t e;
        found = 0;
        k = 0;
        for (int unsigned s = 1; s <= N; s++) begin
          int unsigned c;
          c = (last_id + s) % N;
          if (!found && req[c]) begin
            found = 1;
            k = c;
          end
        end
        e.cyc  = cyc;
        e.data = W'(req_data >> (k * W));
        e.id   = k;
        e.ackv = N'(1) << k;
        exp_q.push_back(e);
        last_id  = k;
        next_ok  = cyc + H + 1;
        hold_end = cyc + H;
        cur_word = e.data;
        cur_id   = k;
      end
    end
  end

  // Monitor: compares DUT outputs against the model between edges.
  initial begin
    forever begin
      @(negedge clka);
      if (!clka_rst) begin
        check("en_eq_or_ack", 32'(bus_en), 32'(|ack));
        check("busy", 32'(busy), 32'(cyc < hold_end));
        check("bus_d_held", 32'(bus_d), 32'(cur_word));
        check("src_id_held", 32'(src_id), cur_id);
        if (bus_en || ack != '0) begin
          launch_t o;
          o.cyc = cyc; o.data = bus_d; o.id = 32'(src_id); o.ackv = ack;
          log_q.push_back(o);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_launch: got launch id %0d data 0x%0h, required none (cycle %0d)", src_id, bus_d, cyc);
          end else begin
            launch_t e;
            e = exp_q.pop_front();
            check("launch_cyc", cyc, e.cyc);
            check("launch_data", 32'(bus_d), 32'(e.data));
            check("launch_id", 32'(src_id), e.id);
            check("launch_ack", 32'(ack), 32'(e.ackv));
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          checks++; errors++;
          $display("FAIL missing_launch: got none, required id %0d at cycle %0d", exp_q[0].id, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Randomized requesters: drop req 0..H-1 cycles after ack, sometimes keep it high.
  initial begin
    for (int i = 0; i < N; i++) drop_in[i] = -1;
    forever begin
      @(negedge clka);
      if (auto_en) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (ack[i]) begin
            if ($urandom_range(0, 7) != 0) drop_in[i] = int'($urandom_range(0, H - 1));
          end
          if (drop_in[i] >= 0) begin
            if (drop_in[i] == 0) begin
              req[i] = 1'b0;
              drop_in[i] = -1;
            end else begin
              drop_in[i]--;
            end
          end else if (!req[i]) begin
            if ($urandom_range(0, 3) == 0) begin
              req_data[i*W +: W] = W'($urandom);
              req[i] = 1'b1;
            end
          end else if ($urandom_range(0, 49) == 0) begin
            req[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic to_neg(input int unsigned n);
    do @(negedge clka); while (cyc < n);
  endtask

  task automatic apply_reset();
    @(negedge clka);
    clka_rst = 1'b1;
    repeat (2) @(negedge clka);
    clka_rst = 1'b0;
    log_q.delete();
  endtask

  // Caller is at a falling edge; reset is raised between edges.
  task automatic mid_reset();
    #2;
    clka_rst = 1'b1;
    #1;
    check("rst_bus_d", 32'(bus_d), 32'(RV));
    check("rst_bus_en", 32'(bus_en), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_src_id", 32'(src_id), 0);
    @(posedge clka);
    @(negedge clka);
    clka_rst = 1'b0;
  endtask

  task automatic chk_log(input string t, input int unsigned idx, input int unsigned c,
                         input logic [W-1:0] d, input int unsigned id);
    if (log_q.size() <= idx) begin
      checks++; errors++;
      $display("FAIL %s: got %0d launches, required more than %0d", t, log_q.size(), idx);
    end else begin
      check({t, "_cyc"}, log_q[idx].cyc, c);
      check({t, "_data"}, 32'(log_q[idx].data), 32'(d));
      check({t, "_id"}, log_q[idx].id, id);
      check({t, "_ack"}, 32'(log_q[idx].ackv), 32'(1) << id);
    end
  endtask

  initial begin
    int unsigned base;
    #(2_000_000);
    $display("FAIL watchdog: simulation did not end, required end before time limit");
    $fatal(1);
  end

  initial begin
    int unsigned base;

    apply_reset();
    check("reset_bus_d", 32'(bus_d), 32'(RV));
    check("reset_busy", 32'(busy), 0);

    // Single request from requester 2
    base = cyc;
    req_data[2*W +: W] = 8'hA5;
    req = 4'b0100;
    to_neg(base + 1);
    req = '0;
    to_neg(base + 6);
    check("t2_busy_e6", 32'(busy), 1);
    to_neg(base + 7);
    check("t2_busy_e7", 32'(busy), 0);
    check("t2_count", log_q.size(), 1);
    chk_log("t2", 0, base + 1, 8'hA5, 2);

    // All four requesting continuously
    apply_reset();
    base = cyc;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    to_neg(base + 29);
    req = '0;
    to_neg(base + 37);
    check("t3_count", log_q.size(), 5);
    for (int unsigned k = 0; k < 5; k++)
      chk_log("t3", k, base + 1 + 7 * k, 8'h10 + 8'(k % 4), k % 4);

    // Held-high requester 1 alternates with late requester 3
    apply_reset();
    base = cyc;
    req_data[1*W +: W] = 8'h21;
    req = 4'b0010;
    to_neg(base + 3);
    req_data[3*W +: W] = 8'h43;
    req[3] = 1'b1;
    to_neg(base + 22);
    req = '0;
    to_neg(base + 30);
    check("t4_count", log_q.size(), 4);
    chk_log("t4a", 0, base + 1, 8'h21, 1);
    chk_log("t4b", 1, base + 8, 8'h43, 3);
    chk_log("t4c", 2, base + 15, 8'h21, 1);
    chk_log("t4d", 3, base + 22, 8'h43, 3);

    // Reset mid-HOLD with requester 0 still requesting
    apply_reset();
    base = cyc;
    req_data[0*W +: W] = 8'h5A;
    req = 4'b0001;
    to_neg(base + 3);
    mid_reset();
    to_neg(base + 5);
    req = '0;
    to_neg(base + 13);
    check("t5_count", log_q.size(), 2);
    chk_log("t5a", 0, base + 1, 8'h5A, 0);
    chk_log("t5b", 1, base + 5, 8'h5A, 0);

    // Randomized traffic with occasional resets
    apply_reset();
    auto_en = 1;
    for (int blk = 0; blk < 8; blk++) begin
      repeat (500) @(negedge clka);
      mid_reset();
    end
    repeat (200) @(negedge clka);
    auto_en = 0;
    @(negedge clka);
    req = '0;
    repeat (2 * H + 4) @(negedge clka);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
